// File: rtl/tdp_march_bist.sv
// March C- BIST initiator for one port of a true-dual-port RAM; busy lasts 11*DEPTH cycles, done one cycle later.
// No backpressure: the RAM port is driven every cycle; start is only accepted in IDLE.
module tdp_march_bist #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 11,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_RD,
    S_CMP,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_ADDR = '0;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;
  localparam logic [ERR_W-1:0]  ERR_ONE    = ERR_W'(1);
  localparam logic [2:0]        ELEM_LAST  = 3'd5;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          elem_q, elem_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  logic                pass_q, pass_d;

  logic                elem_down;
  logic                next_down;
  logic                expect_ones;
  logic [DATA_W-1:0]   expect_dat;
  logic                miscmp;
  logic                elem_end;

  // E3/E4 walk the array downwards; E2/E4 expect all-ones on read.
  assign elem_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign next_down   = (elem_q == 3'd2) || (elem_q == 3'd3);
  assign expect_ones = (elem_q == 3'd2) || (elem_q == 3'd4);
  assign expect_dat  = expect_ones ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  assign miscmp      = (mem_dout != expect_dat);
  assign elem_end    = elem_down ? (addr_q == FIRST_ADDR) : (addr_q == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      elem_q      <= '0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      elem_q      <= elem_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    elem_d      = elem_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    pass_d      = pass_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WR0;
          addr_d      = FIRST_ADDR;
          elem_d      = 3'd0;
          err_cnt_d   = '0;
          fail_addr_d = '0;
          fail_elem_d = '0;
          pass_d      = 1'b0;
        end
      end

      S_WR0: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q;
        if (addr_q == LAST_ADDR) begin
          state_d = S_RD;
          elem_d  = 3'd1;
          addr_d  = FIRST_ADDR;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end

      S_RD: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        state_d  = S_CMP;
      end

      S_CMP: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        if (elem_q != ELEM_LAST) begin
          mem_we  = 1'b1;
          mem_din = ~expect_dat;
        end
        // err_cnt still zero means this is the first miscompare of the run.
        if (miscmp) begin
          err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_ONE;
          if (err_cnt_q == '0) begin
            fail_addr_d = addr_q;
            fail_elem_d = elem_q;
          end
        end
        if (!elem_end) begin
          state_d = S_RD;
          addr_d  = elem_down ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
        end else if (elem_q == ELEM_LAST) begin
          state_d = S_DONE;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d = S_RD;
          elem_d  = elem_q + 3'd1;
          addr_d  = next_down ? LAST_ADDR : FIRST_ADDR;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;

endmodule
